btn_event: RTL and testbench



---
 rtl/btn_event_pkg.sv | 19 +
 rtl/btn_event_edge_det.sv | 33 +++
 rtl/btn_event.sv | 135 +++++++++++++
 tb/tb_btn_event.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/btn_event_pkg.sv
// Shared types and defaults for the button event classifier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package btn_event_pkg;

  // Default counter width and timing at a 50 MHz system clock.
  localparam int unsigned CW_DEF     = 28;
  localparam logic [27:0] T_LONG_DEF = 28'd50_000_000; // 1 s hold
  localparam logic [27:0] T_DBL_DEF  = 28'd12_500_000; // 250 ms gap

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    LONG_HELD = 3'd2,
    WAIT2     = 3'd3,
    PRESS2    = 3'd4
  } state_t;

endpackage

// File: rtl/btn_event_edge_det.sv
// Edge detector for a clean, synchronous level: one register, comb rise/fall.
// Latency: rise/fall valid in the cycle the new level is presented.
// Backpressure: none.
// Ports: clk, n_rst (async active-low), btn (level in), rise/fall (comb out).
module edge_det (
  input  logic clk,
  input  logic n_rst,
  input  logic btn,
  output logic rise,
  output logic fall
);

  logic btn_d1_q;
  logic btn_d1_d;

  always_comb begin
    btn_d1_d = btn;
  end

  // Resetting to 0 means a button already held at reset release is
  // seen as a fresh rise on the first edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      btn_d1_q <= 1'b0;
    end else begin
      btn_d1_q <= btn_d1_d;
    end
  end

  assign rise = btn & ~btn_d1_q;
  assign fall = ~btn & btn_d1_q;

endmodule

// File: rtl/btn_event.sv
// Classifies button gestures into short press, long press or double click.
// Latency: each event pulse is registered, one cycle after the deciding edge.
// Backpressure: none; pulses are single-cycle and must be consumed immediately.
// Ports: clk, n_rst (async active-low), btn (debounced level, 1 = pressed),
//        short_press / long_press / double_click (1-cycle pulses), busy.
module btn_event
  import btn_event_pkg::*;
#(
  parameter int unsigned    CW     = CW_DEF,
  parameter logic [CW-1:0]  T_LONG = CW'(T_LONG_DEF),
  parameter logic [CW-1:0]  T_DBL  = CW'(T_DBL_DEF)
) (
  input  logic clk,
  input  logic n_rst,
  input  logic btn,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic busy
);

  logic rise;
  logic fall;

  edge_det u_edge_det (
    .clk   (clk),
    .n_rst (n_rst),
    .btn   (btn),
    .rise  (rise),
    .fall  (fall)
  );

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            short_q, short_d;
  logic            long_q, long_d;
  logic            dbl_q, dbl_d;
  logic            busy_q, busy_d;

  // Saturating increment: the counter must never wrap back to zero.
  function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] c);
    return (c == '1) ? c : c + CW'(1);
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    dbl_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = PRESS1;
          cnt_d   = '0;
        end
      end

      PRESS1: begin
        if (fall) begin
          state_d = WAIT2;
          cnt_d   = '0;
        end else if (cnt_q == T_LONG - CW'(1)) begin
          state_d = LONG_HELD;
          cnt_d   = '0;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_inc(cnt_q);
        end
      end

      LONG_HELD: begin
        if (fall) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end

      WAIT2: begin
        // A rise on the timeout edge still counts as a double click.
        if (rise) begin
          state_d = PRESS2;
          cnt_d   = '0;
          dbl_d   = 1'b1;
        end else if (cnt_q == T_DBL - CW'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          short_d = 1'b1;
        end else begin
          cnt_d = cnt_inc(cnt_q);
        end
      end

      PRESS2: begin
        // Second press is never timed; only its release matters.
        if (fall) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      dbl_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      short_q <= short_d;
      long_q  <= long_d;
      dbl_q   <= dbl_d;
      busy_q  <= busy_d;
    end
  end

  assign short_press  = short_q;
  assign long_press   = long_q;
  assign double_click = dbl_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_btn_event.sv
// Directed bench for btn_event with T_LONG=10, T_DBL=6, CW=8.
// Outputs are observed 1 time unit after each rising edge, as the vector
// {short_press, long_press, double_click, busy}.
module tb_btn_event;

  logic clk   = 1'b0;
  logic n_rst = 1'b1;
  logic btn   = 1'b0;
  logic short_press;
  logic long_press;
  logic double_click;
  logic busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  btn_event #(
    .CW     (8),
    .T_LONG (8'd10),
    .T_DBL  (8'd6)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .btn          (btn),
    .short_press  (short_press),
    .long_press   (long_press),
    .double_click (double_click),
    .busy         (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] obs;
    logic [3:0] exp;
    #2 n_rst = 1'b0;
    btn = 1'b0;
    tick();
    tick();
    obs = {short_press, long_press, double_click, busy};
    checks++;
    if (obs !== 4'b0000) begin
      errors++;
      $display("FAIL reset_hold got %b exp 0000", obs);
    end
    n_rst = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      obs = {short_press, long_press, double_click, busy};
      exp = 4'b0000;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL reset_idle cyc %0d got %b exp %b", k, obs, exp);
      end
    end
  endtask

  // Rise edge = tick 1, held 4 cycles, fall edge = tick 5, short at 5+6.
  task automatic test_short();
    logic [3:0] obs;
    logic [3:0] exp;
    btn = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      obs = {short_press, long_press, double_click, busy};
      exp = {(k == 11), 1'b0, 1'b0, (k <= 10)};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL short cyc %0d got %b exp %b", k, obs, exp);
      end
      if (k == 4) btn = 1'b0;
    end
  endtask

  // Rise edge = tick 1, long pulse 10 edges later; release is silent.
  task automatic test_long();
    logic [3:0] obs;
    logic [3:0] exp;
    btn = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      tick();
      obs = {short_press, long_press, double_click, busy};
      exp = {1'b0, (k == 11), 1'b0, (k <= 30)};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL long cyc %0d got %b exp %b", k, obs, exp);
      end
      if (k == 30) btn = 1'b0;
    end
  endtask

  // Held 3 cycles, fall edge tick 4, second rise edge tick 6 (2 after fall),
  // second press held 20 cycles, fall edge tick 26.
  task automatic test_double();
    logic [3:0] obs;
    logic [3:0] exp;
    btn = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      obs = {short_press, long_press, double_click, busy};
      exp = {1'b0, 1'b0, (k == 6), (k <= 25)};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL double cyc %0d got %b exp %b", k, obs, exp);
      end
      if (k == 3)  btn = 1'b0;
      if (k == 5)  btn = 1'b1;
      if (k == 25) btn = 1'b0;
    end
  endtask

  // Fall edge tick 3; re-press sampled on tick 9, the timeout edge.
  task automatic test_dbl_timeout();
    logic [3:0] obs;
    logic [3:0] exp;
    btn = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      obs = {short_press, long_press, double_click, busy};
      exp = {1'b0, 1'b0, (k == 9), (k <= 10)};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL dbl_timeout cyc %0d got %b exp %b", k, obs, exp);
      end
      if (k == 2)  btn = 1'b0;
      if (k == 8)  btn = 1'b1;
      if (k == 10) btn = 1'b0;
    end
  endtask

  // Reset for one cycle during PRESS1 with the button still held.
  task automatic test_reset_mid();
    logic [3:0] obs;
    logic [3:0] exp;
    btn = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      obs = {short_press, long_press, double_click, busy};
      checks++;
      if (obs !== 4'b0001) begin
        errors++;
        $display("FAIL mid_pre cyc %0d got %b exp 0001", k, obs);
      end
    end
    n_rst = 1'b0;
    #1;
    obs = {short_press, long_press, double_click, busy};
    checks++;
    if (obs !== 4'b0000) begin
      errors++;
      $display("FAIL mid_rst_async got %b exp 0000", obs);
    end
    tick();
    obs = {short_press, long_press, double_click, busy};
    checks++;
    if (obs !== 4'b0000) begin
      errors++;
      $display("FAIL mid_rst_hold got %b exp 0000", obs);
    end
    n_rst = 1'b1;
    for (int m = 1; m <= 22; m++) begin
      tick();
      obs = {short_press, long_press, double_click, busy};
      exp = {1'b0, (m == 11), 1'b0, (m <= 20)};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL mid_after cyc %0d got %b exp %b", m, obs, exp);
      end
      if (m == 20) btn = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_short();
    test_long();
    test_double();
    test_dbl_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
